// File: rtl/muldiv_if.sv
// Issue/result bundle between control, the register file read ports and the mul/div unit.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; the sign is fixed up in a single FIX cycle.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (op[1] = divide, op[0] = unsigned).
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    opb_q, opb_d;       // mul: multiplicand, div: divisor
  logic [2*WIDTH-1:0]  acc_q, acc_d;       // mul: {partial, multiplier}, div: {rem, quotient}
  logic                neg_q, neg_d;       // product / quotient negative
  logic                rneg_q, rneg_d;     // remainder negative
  logic                dz_q, dz_d;         // divide by zero
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                done_q, done_d;

  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      rem_sh, rem_diff;
  logic                rem_ge;
  logic [2*WIDTH-1:0]  mul_next, div_next, prod;
  logic [WIDTH-1:0]    quo, rem;

  // Operand magnitudes at issue; unsigned ops pass through untouched.
  always_comb begin
    a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  // One shift-add or restoring-divide step, plus the sign fix-up of the final result.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow.
    rem_ge   = ~rem_diff[WIDTH];
    div_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next state: IDLE -> CALC -> FIX -> IDLE only.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StCalc;
      StCalc:  if (cnt_q == CntLast) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and HI/LO next values.
  always_comb begin
    op_d   = op_q;
    opb_d  = opb_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // start wins over a same-cycle mthi/mtlo
          op_d   = bus.op;
          opb_d  = bus.op[1] ? b_mag : a_mag;
          acc_d  = {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          dz_d   = (bus.b == '0);
          cnt_d  = '0;
        end else begin
          if (bus.mthi) hi_d = bus.a;
          if (bus.mtlo) lo_d = bus.a;
        end
      end
      StCalc: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
      end
      StFix: begin
        done_d = 1'b1;
        if (op_q[1]) begin
          hi_d = rem;
          lo_d = dz_q ? '1 : quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table through a result scoreboard, plus hand-written
// sequences for busy-time interference, start/mt* priority and mid-op reset.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int          Lat = 33;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          e_cyc;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;
  int   busy_cnt;
  int   done_cnt;
  exp_t sb[$];
  vec_t vecs[14];

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and sample the DUT there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        chk("done_with_busy", {31'b0, bus.busy}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no done");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, bus.hi, e.hi);
          chk({e.name, "_lo"}, bus.lo, e.lo);
          chk({e.name, "_latency"}, 32'(cyc - e.e_cyc), 32'(Lat));
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input string name,
                       input logic with_mthi);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.mthi  = with_mthi;
    sb.push_back('{hi: ehi, lo: elo, e_cyc: cyc + 1, name: name});
    busy_cnt  = 0;
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(Lat));
  endtask

  initial begin
    int d0;
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;

    vecs[0]  = '{op: 2'b01, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFE, lo: 32'h00000001, name: "multu_max"};
    vecs[1]  = '{op: 2'b00, a: 32'hFFFFFFFD, b: 32'h00000007, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFEB, name: "mult_neg3x7"};
    vecs[2]  = '{op: 2'b10, a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, name: "div_neg7by2"};
    vecs[3]  = '{op: 2'b11, a: 32'd100,      b: 32'd7,        hi: 32'd2,        lo: 32'd14,       name: "divu_100by7"};
    vecs[4]  = '{op: 2'b11, a: 32'd5,        b: 32'd0,        hi: 32'd5,        lo: 32'hFFFFFFFF, name: "divu_by0"};
    vecs[5]  = '{op: 2'b10, a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000, name: "div_ovf"};
    vecs[6]  = '{op: 2'b00, a: 32'h80000000, b: 32'h80000000, hi: 32'h40000000, lo: 32'h00000000, name: "mult_minsq"};
    vecs[7]  = '{op: 2'b00, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h00000001, name: "mult_m1sq"};
    vecs[8]  = '{op: 2'b01, a: 32'h00010000, b: 32'h00010000, hi: 32'h00000001, lo: 32'h00000000, name: "multu_carry"};
    vecs[9]  = '{op: 2'b10, a: 32'd7,        b: 32'hFFFFFFFE, hi: 32'h00000001, lo: 32'hFFFFFFFD, name: "div_7bym2"};
    vecs[10] = '{op: 2'b10, a: 32'hFFFFFFF9, b: 32'd0,        hi: 32'hFFFFFFF9, lo: 32'hFFFFFFFF, name: "div_neg_by0"};
    vecs[11] = '{op: 2'b11, a: 32'hFFFFFFFF, b: 32'd1,        hi: 32'h00000000, lo: 32'hFFFFFFFF, name: "divu_by1"};
    vecs[12] = '{op: 2'b10, a: 32'hFFFFFF9C, b: 32'd7,        hi: 32'hFFFFFFFE, lo: 32'hFFFFFFF2, name: "div_neg100by7"};
    vecs[13] = '{op: 2'b00, a: 32'h7FFFFFFF, b: 32'hFFFFFFFF, hi: 32'hFFFFFFFF, lo: 32'h80000001, name: "mult_maxxm1"};

    // Reset state
    tick();
    tick();
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name, 1'b0);
      wait_done(vecs[i].name);
      tick();
    end

    // mthi / mtlo individually in IDLE
    bus.a    = 32'h00005555;
    bus.mthi = 1'b1;
    tick();
    bus.mthi = 1'b0;
    chk("mthi_hi", bus.hi, 32'h00005555);
    bus.a    = 32'h0000A5A5;
    bus.mtlo = 1'b1;
    tick();
    bus.mtlo = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h0000A5A5);
    chk("mtlo_hi_kept", bus.hi, 32'h00005555);

    // start with mthi in the same cycle: start wins
    issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, "start_vs_mthi", 1'b1);
    chk("start_vs_mthi_dropped", bus.hi, 32'h00005555);
    wait_done("start_vs_mthi");
    tick();

    // start and mthi while busy are ignored; exactly one done
    d0 = done_cnt;
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "busy_ignore", 1'b0);
    for (int i = 0; i < 5; i++) tick();
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'h0000DEAD;
    bus.b     = 32'd1;
    bus.mthi  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    chk("busy_mthi_dropped", bus.hi, 32'd0);
    wait_done("busy_ignore");
    for (int i = 0; i < 40; i++) tick();
    chk("busy_ignore_one_done", 32'(done_cnt - d0), 32'd1);
    chk("busy_ignore_lo_stable", bus.lo, 32'd42);

    // Reset at cnt=10 of a DIV: abort with no done
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'h7FFFFFFF;
    bus.b     = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
    chk("midrst_done", {31'b0, bus.done}, 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    bus.a    = 32'h00001234;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mt_both_hi", bus.hi, 32'h00001234);
    chk("mt_both_lo", bus.lo, 32'h00001234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
